sm_trace_buffer: RTL and testbench

Hardware instruction-trace capture for the schoolMIPS core, sitting directly downstream of `sm_top`. It samples the CPU's word PC and the current instruction word on each CPU step, stamps each sample with a step number, and buffers the records in a first-word-fall-through FIFO. A debug consumer (UART bridge, JTAG mailbox) drains the FIFO through a valid/ready port, giving on silicon the same per-cycle pc/instr log the simulation bench prints.

---
 rtl/sm_trace_buffer.sv | 159 +++++++++++++++
 tb/tb_sm_trace_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer
//   Instruction-trace capture for the schoolMIPS core. On every qualified CPU
//   step (trace_en & sample_en) the current word PC and instruction are
//   stamped with a 16-bit step number and pushed into a first-word-fall-through
//   FIFO of 2^DEPTH_LOG2 records. A debug consumer drains it over valid/ready.
//
//   Optional feature: define SM_TRACE_DEDUP_EN to suppress records whose PC
//   equals the PC of the previous qualified step (stalled CPU). The step
//   stamp still advances on every qualified step, so gaps expose the stalls.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   sample_en, trace_en   CPU step strobe, capture enable
//   clear                 synchronous flush of FIFO, counters and dedup state
//   pc, instr             sampled word PC and instruction word
//   out_valid/out_ready   head-record handshake
//   out_pc/out_instr/out_seq  head record, zero while out_valid=0
//   level                 number of stored records
//   overflow, drop_cnt    sticky drop flag, saturating dropped-record count
module sm_trace_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic                  trace_en,
  input  logic                  clear,
  input  logic [31:0]           pc,
  input  logic [31:0]           instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_instr,
  output logic [15:0]           out_seq,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [31:0] memPc    [DEPTH];
  logic [31:0] memInstr [DEPTH];
  logic [15:0] memSeq   [DEPTH];

  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [PW-1:0]         levelQ;
  logic [15:0]           seq;
  logic [15:0]           dropCnt;
  logic                  overflowQ;
  logic [DEPTH_LOG2-1:0] wrIdx;
  logic [DEPTH_LOG2-1:0] rdIdx;
  logic                  qs;
  logic                  cap;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign qs    = trace_en & sample_en;
  assign wrIdx = wrPtr[DEPTH_LOG2-1:0];
  assign rdIdx = rdPtr[DEPTH_LOG2-1:0];
  // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PW-1] != rdPtr[PW-1]) && (wrIdx == rdIdx);
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = cap && (!full || pop);
  assign drop  = cap && full && !pop;

`ifdef SM_TRACE_DEDUP_EN
  logic [31:0] lastPc;
  logic        lastVld;

  assign cap = qs && (!lastVld || (pc != lastPc));

  // lastPc follows every qualified step, even dropped ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastVld <= 1'b0;
    end else if (clear) begin
      lastVld <= 1'b0;
    end else if (qs) begin
      lastVld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (qs) begin
      lastPc <= pc;
    end
  end
`else
  assign cap = qs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      levelQ    <= '0;
      seq       <= '0;
      dropCnt   <= '0;
      overflowQ <= 1'b0;
    end else if (clear) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      levelQ    <= '0;
      seq       <= '0;
      dropCnt   <= '0;
      overflowQ <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (push && !pop) begin
        levelQ <= levelQ + PTR_ONE;
      end else if (pop && !push) begin
        levelQ <= levelQ - PTR_ONE;
      end
      if (qs) begin
        seq <= seq + 16'd1;
      end
      if (drop) begin
        overflowQ <= 1'b1;
        if (dropCnt != 16'hFFFF) begin
          dropCnt <= dropCnt + 16'd1;
        end
      end
    end
  end

  // Record storage; no reset, occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      memPc[wrIdx]    <= pc;
      memInstr[wrIdx] <= instr;
      memSeq[wrIdx]   <= seq;
    end
  end

  // Head is read asynchronously from registered pointers only; gated to zero
  // when empty so an asynchronous reset clears the port at once.
  assign out_valid = !empty;
  assign out_pc    = empty ? 32'd0 : memPc[rdIdx];
  assign out_instr = empty ? 32'd0 : memInstr[rdIdx];
  assign out_seq   = empty ? 16'd0 : memSeq[rdIdx];
  assign level     = levelQ;
  assign overflow  = overflowQ;
  assign drop_cnt  = dropCnt;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Self-checking bench for sm_trace_buffer: a queue-based reference model
// compared against every DUT output after each clock edge, plus literal
// expectations for the directed scenarios.
module tb_sm_trace_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic        trace_en;
  logic        clear;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [15:0] out_seq;
  logic [DL:0] level;
  logic        overflow;
  logic [15:0] drop_cnt;

  sm_trace_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .trace_en(trace_en),
    .clear(clear), .pc(pc), .instr(instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_seq(out_seq), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] seq;
  } rec_t;

  rec_t        q[$];
  logic [15:0] mSeq;
  logic [15:0] mDrop;
  logic        mOv;
`ifdef SM_TRACE_DEDUP_EN
  logic [31:0] mLastPc;
  logic        mLastVld;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mSeq  = '0;
    mDrop = '0;
    mOv   = 1'b0;
`ifdef SM_TRACE_DEDUP_EN
    mLastVld = 1'b0;
    mLastPc  = '0;
`endif
  endtask

  task automatic cmpAll();
    bit v;
    v = (q.size() != 0);
    chk("valid",    64'(out_valid), 64'(v));
    chk("out_pc",   64'(out_pc),    v ? 64'(q[0].pc)    : 64'd0);
    chk("out_instr",64'(out_instr), v ? 64'(q[0].instr) : 64'd0);
    chk("out_seq",  64'(out_seq),   v ? 64'(q[0].seq)   : 64'd0);
    chk("level",    64'(level),     64'(q.size()));
    chk("overflow", 64'(overflow),  64'(mOv));
    chk("drop_cnt", 64'(drop_cnt),  64'(mDrop));
  endtask

  // One clock: predict from the pre-edge inputs and state, then compare.
  task automatic step();
    bit          qs, cap, popv, clr;
    logic [31:0] p, ins;
    rec_t        r;
    qs   = trace_en && sample_en;
    popv = (q.size() != 0) && out_ready;
    clr  = clear;
    p    = pc;
    ins  = instr;
`ifdef SM_TRACE_DEDUP_EN
    cap = qs && (!mLastVld || p != mLastPc);
`else
    cap = qs;
`endif
    @(posedge clk);
    #1;
    if (clr) begin
      modelReset();
    end else begin
      if (popv) r = q.pop_front();
      if (cap) begin
        if (q.size() < DEPTH) begin
          q.push_back('{pc: p, instr: ins, seq: mSeq});
        end else begin
          mOv = 1'b1;
          if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
        end
      end
      if (qs) begin
        mSeq = mSeq + 16'd1;
`ifdef SM_TRACE_DEDUP_EN
        mLastVld = 1'b1;
        mLastPc  = p;
`endif
      end
    end
    cmpAll();
  endtask

  task automatic setIn(input logic se, input logic te, input logic clr,
                       input logic rdy, input logic [31:0] p, input logic [31:0] ins);
    sample_en = se;
    trace_en  = te;
    clear     = clr;
    out_ready = rdy;
    pc        = p;
    instr     = ins;
  endtask

  logic [31:0] basicInstr [3];

  initial begin
    basicInstr[0] = 32'h24020005;
    basicInstr[1] = 32'h00000000;
    basicInstr[2] = 32'h1000FFFF;

    rst_n = 1'b0;
    setIn(0, 0, 0, 0, 0, 0);
    modelReset();
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level),     64'd0);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_drop",  64'(drop_cnt),  64'd0);
    chk("rst_pc",    64'(out_pc),    64'd0);
    rst_n = 1'b1;

    // Basic capture
    for (int i = 0; i < 3; i++) begin
      setIn(1, 1, 0, 0, 32'(i), basicInstr[i]);
      step();
    end
    setIn(0, 1, 0, 0, 0, 0);
    chk("basic_level", 64'(level),     64'd3);
    chk("basic_pc",    64'(out_pc),    64'd0);
    chk("basic_instr", 64'(out_instr), 64'h24020005);
    chk("basic_seq",   64'(out_seq),   64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_seq", 64'(out_seq), 64'(i));
      step();
    end
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Fill and overflow from a cleared state
    setIn(0, 0, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      setIn(1, 1, 0, 0, 32'(i + 16), 32'(i * 3));
      step();
    end
    chk("fill_level", 64'(level),    64'd16);
    chk("fill_ovf",   64'(overflow), 64'd1);
    chk("fill_drop",  64'(drop_cnt), 64'd4);
    chk("fill_seq",   64'(out_seq),  64'd0);

    // Full with simultaneous pop and push
    setIn(1, 1, 0, 1, 32'd100, 32'hABCD0001);
    step();
    chk("fullpp_level", 64'(level),    64'd16);
    chk("fullpp_drop",  64'(drop_cnt), 64'd4);
    setIn(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step();
    chk("tail_seq", 64'(out_seq), 64'd20);
    chk("tail_pc",  64'(out_pc),  64'd100);

    // Clear beats push and pop
    setIn(1, 1, 1, 1, 32'd7, 32'd7);
    step();
    chk("clr_level", 64'(level),     64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_drop",  64'(drop_cnt),  64'd0);
    setIn(1, 1, 0, 0, 32'd200, 32'd1);
    step();
    chk("clr_nextseq", 64'(out_seq), 64'd0);

    // Stalled-PC sequence
    setIn(0, 0, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      setIn(1, 1, 0, 0, (i == 3) ? 32'd6 : 32'd5, 32'(i));
      step();
    end
`ifdef SM_TRACE_DEDUP_EN
    chk("dedup_level", 64'(level),   64'd2);
    chk("dedup_pc0",   64'(out_pc),  64'd5);
    chk("dedup_seq0",  64'(out_seq), 64'd0);
    setIn(0, 0, 0, 1, 0, 0);
    step();
    chk("dedup_pc1",   64'(out_pc),  64'd6);
    chk("dedup_seq1",  64'(out_seq), 64'd3);
`else
    chk("nodedup_level", 64'(level),   64'd4);
    chk("nodedup_seq0",  64'(out_seq), 64'd0);
`endif

    // Asynchronous reset with 7 records stored
    setIn(0, 0, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      setIn(1, 1, 0, 0, 32'(i + 40), 32'(i));
      step();
    end
    setIn(0, 0, 0, 0, 0, 0);
    chk("pre_rst_level", 64'(level), 64'd7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level),     64'd0);
    chk("arst_pc",    64'(out_pc),    64'd0);
    modelReset();
    #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      setIn(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 4),
            32'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
